// File: rtl/cpu_rf_pkg.sv
// Shared register-file types: default index width, register count, index type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_rf_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int N_DEF     = 2 ** SEL_W_DEF;

  typedef logic [SEL_W_DEF-1:0] reg_idx_t;

  // Register count for an arbitrary index width.
  function automatic int num_regs(input int sel_w);
    return 2 ** sel_w;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-way one-hot decoder with enable (generalised 3-to-8).
// Latency: 0 cycles.
// Backpressure: none; pure function of its inputs.
module decoder_onehot #(
  parameter int SEL_W = cpu_rf_pkg::SEL_W_DEF
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      in,
  output logic [2**SEL_W-1:0]   y
);

  // Single hot bit at position 'in' when enabled, all zeros otherwise.
  always_comb begin
    y = '0;
    if (en) y[in] = 1'b1;
  end

endmodule

// File: rtl/rf_wr_decoder_sb.sv
// Register-file write-enable decoder plus busy scoreboard with read-port hazard check.
// Latency: we/busy/waw_err 1 cycle after wb/iss; busy_a/busy_b/stall combinational.
// Backpressure: none; every iss/wb cycle is consumed, upstream holds issue on stall.
module rf_wr_decoder_sb
  import cpu_rf_pkg::*;
#(
  parameter int SEL_W    = SEL_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_en,
  input  logic [SEL_W-1:0]     iss_sel,
  input  logic                 wb_en,
  input  logic [SEL_W-1:0]     wb_sel,
  input  logic [SEL_W-1:0]     rd_sel_a,
  input  logic [SEL_W-1:0]     rd_sel_b,
  output logic [2**SEL_W-1:0]  we,
  output logic [2**SEL_W-1:0]  busy,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 stall,
  output logic                 waw_err
);

  localparam int N = 2 ** SEL_W;

  // Bits allowed to ever be written or marked busy; r0 excluded when hardwired.
  localparam logic [N-1:0] KEEP_MASK = ZERO_REG ? {{(N-1){1'b1}}, 1'b0} : {N{1'b1}};

  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic         iss_is_r0;
  logic         waw_hit;
  logic         hit_a;
  logic         hit_b;

  decoder_onehot #(.SEL_W(SEL_W)) u_dec_iss (
    .en (iss_en),
    .in (iss_sel),
    .y  (set_mask)
  );

  decoder_onehot #(.SEL_W(SEL_W)) u_dec_wb (
    .en (wb_en),
    .in (wb_sel),
    .y  (clr_mask)
  );

  // Issue to an already-busy register not being retired this cycle is a WAW hazard.
  always_comb begin
    iss_is_r0 = ZERO_REG && (iss_sel == '0);
    waw_hit   = iss_en && busy[iss_sel] && !(wb_en && (wb_sel == iss_sel)) && !iss_is_r0;
  end

  // Write enables and scoreboard update; set is applied after clear so issue wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      we      <= '0;
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      we      <= clr_mask & KEEP_MASK;
      busy    <= ((busy & ~clr_mask) | set_mask) & KEEP_MASK;
      waw_err <= waw_err | waw_hit;
    end
  end

  // Read-port hazard: pending unless the same register is being written back right now.
  always_comb begin
    hit_a  = busy[rd_sel_a] && !(wb_en && (wb_sel == rd_sel_a)) && !(ZERO_REG && (rd_sel_a == '0));
    hit_b  = busy[rd_sel_b] && !(wb_en && (wb_sel == rd_sel_b)) && !(ZERO_REG && (rd_sel_b == '0));
    busy_a = hit_a;
    busy_b = hit_b;
    stall  = hit_a | hit_b;
  end

endmodule

// File: tb/tb_rf_wr_decoder_sb.sv
module tb_rf_wr_decoder_sb;

  typedef struct {
    logic       rst;
    logic       ie;
    logic [2:0] is;
    logic       wbe;
    logic [2:0] ws;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       ea;
    logic       eb;
    logic [7:0] ewe;
    logic [7:0] ebusy;
    logic       ewaw;
    logic [7:0] ewe_z0;
  } vec_t;

  typedef struct {
    logic [7:0] we;
    logic [7:0] busy;
    logic       waw;
    logic [7:0] we_z0;
  } exp_t;

  typedef struct {
    logic [31:0] we;
    logic [31:0] busy;
    logic        waw;
  } exp5_t;

  logic clk = 1'b0;
  logic reset;
  logic iss_en, wb_en;
  logic [2:0] iss_sel, wb_sel, rd_sel_a, rd_sel_b;
  logic [7:0] we3, busy3, we_z, busy_z;
  logic busy_a3, busy_b3, stall3, waw3;
  logic ba_z, bb_z, st_z, waw_z;

  logic iss_en5, wb_en5;
  logic [4:0] iss_sel5, wb_sel5, rd_a5, rd_b5;
  logic [31:0] we5, busy5;
  logic busy_a5, busy_b5, stall5, waw5;

  int checks = 0;
  int errors = 0;

  exp_t  sb[$];
  exp5_t sb5[$];
  vec_t  tbl[26];

  always #5 clk = ~clk;

  rf_wr_decoder_sb #(.SEL_W(3), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .iss_en(iss_en), .iss_sel(iss_sel),
    .wb_en(wb_en), .wb_sel(wb_sel), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .we(we3), .busy(busy3), .busy_a(busy_a3), .busy_b(busy_b3),
    .stall(stall3), .waw_err(waw3)
  );

  rf_wr_decoder_sb #(.SEL_W(3), .ZERO_REG(1'b0)) dut_z0 (
    .clk(clk), .reset(reset), .iss_en(iss_en), .iss_sel(iss_sel),
    .wb_en(wb_en), .wb_sel(wb_sel), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .we(we_z), .busy(busy_z), .busy_a(ba_z), .busy_b(bb_z),
    .stall(st_z), .waw_err(waw_z)
  );

  rf_wr_decoder_sb #(.SEL_W(5), .ZERO_REG(1'b1)) dut_w5 (
    .clk(clk), .reset(reset), .iss_en(iss_en5), .iss_sel(iss_sel5),
    .wb_en(wb_en5), .wb_sel(wb_sel5), .rd_sel_a(rd_a5), .rd_sel_b(rd_b5),
    .we(we5), .busy(busy5), .busy_a(busy_a5), .busy_b(busy_b5),
    .stall(stall5), .waw_err(waw5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic ie, input logic [2:0] is,
                              input logic wbe, input logic [2:0] ws,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic ea, input logic eb,
                              input logic [7:0] ewe, input logic [7:0] ebusy,
                              input logic ewaw);
    vec_t v;
    v.rst = rst; v.ie = ie; v.is = is; v.wbe = wbe; v.ws = ws;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
    v.ewe = ewe; v.ebusy = ebusy; v.ewaw = ewaw;
    v.ewe_z0 = ewe;
    return v;
  endfunction

  // One SEL_W=5 cycle: drive, check combinational outputs, push expectation, check after edge.
  task automatic step5(input string tag, input logic rst, input logic ie, input logic [4:0] is,
                       input logic wbe, input logic [4:0] ws, input logic [4:0] ra,
                       input logic ea, input logic [31:0] ewe, input logic [31:0] ebusy);
    exp5_t e, got;
    reset = rst; iss_en5 = ie; iss_sel5 = is; wb_en5 = wbe; wb_sel5 = ws; rd_a5 = ra; rd_b5 = '0;
    #2;
    chk({tag, " busy_a"}, {31'd0, busy_a5}, {31'd0, ea});
    chk({tag, " stall"},  {31'd0, stall5},  {31'd0, ea});
    e.we = ewe; e.busy = ebusy; e.waw = 1'b0;
    sb5.push_back(e);
    @(posedge clk); #1;
    got = sb5.pop_front();
    chk({tag, " we"},   we5,   got.we);
    chk({tag, " busy"}, busy5, got.busy);
    chk({tag, " waw"},  {31'd0, waw5}, {31'd0, got.waw});
  endtask

  initial begin
    exp_t e, got;

    //            rst ie is wbe ws ra rb  ea eb  we     busy   waw
    tbl[0]  = mk(1, 0, 0, 1, 5, 5, 0,  0, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(1, 0, 0, 1, 5, 5, 0,  0, 0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0, 0, 0, 1, 5, 0, 0,  0, 0, 8'h20, 8'h00, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 0);
    tbl[4]  = mk(0, 1, 3, 0, 0, 3, 0,  0, 0, 8'h00, 8'h08, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 3, 0,  1, 0, 8'h00, 8'h08, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 3, 0,  1, 0, 8'h00, 8'h08, 0);
    tbl[7]  = mk(0, 0, 0, 1, 3, 3, 0,  0, 0, 8'h08, 8'h00, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 3, 0,  0, 0, 8'h00, 8'h00, 0);
    tbl[9]  = mk(0, 1, 6, 0, 0, 0, 0,  0, 0, 8'h00, 8'h40, 0);
    tbl[10] = mk(0, 1, 6, 1, 6, 0, 6,  0, 0, 8'h40, 8'h40, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 6,  0, 1, 8'h00, 8'h40, 0);
    tbl[12] = mk(0, 0, 0, 1, 6, 0, 6,  0, 0, 8'h40, 8'h00, 0);
    tbl[13] = mk(0, 1, 2, 0, 0, 2, 0,  0, 0, 8'h00, 8'h04, 0);
    tbl[14] = mk(0, 1, 2, 0, 0, 2, 0,  1, 0, 8'h00, 8'h04, 1);
    tbl[15] = mk(0, 0, 0, 1, 2, 2, 0,  0, 0, 8'h04, 8'h00, 1);
    tbl[16] = mk(0, 0, 0, 1, 1, 0, 0,  0, 0, 8'h02, 8'h00, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 0);
    tbl[18] = mk(0, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h02, 0);
    tbl[19] = mk(0, 1, 4, 0, 0, 1, 7,  1, 0, 8'h00, 8'h12, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 4,  0, 1, 8'h00, 8'h12, 0);
    tbl[21] = mk(0, 0, 0, 1, 1, 1, 4,  0, 1, 8'h02, 8'h10, 0);
    tbl[22] = mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 8'h00, 8'h10, 0);
    tbl[22].ewe_z0 = 8'h01;
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h10, 0);
    tbl[24] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h10, 0);
    tbl[25] = mk(0, 0, 0, 1, 4, 0, 0,  0, 0, 8'h10, 8'h00, 0);

    reset = 1'b1; iss_en = 0; iss_sel = 0; wb_en = 0; wb_sel = 0; rd_sel_a = 0; rd_sel_b = 0;
    iss_en5 = 0; iss_sel5 = 0; wb_en5 = 0; wb_sel5 = 0; rd_a5 = 0; rd_b5 = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      reset = tbl[i].rst; iss_en = tbl[i].ie; iss_sel = tbl[i].is;
      wb_en = tbl[i].wbe; wb_sel = tbl[i].ws; rd_sel_a = tbl[i].ra; rd_sel_b = tbl[i].rb;
      #2;
      chk($sformatf("row%0d busy_a", i), {31'd0, busy_a3}, {31'd0, tbl[i].ea});
      chk($sformatf("row%0d busy_b", i), {31'd0, busy_b3}, {31'd0, tbl[i].eb});
      chk($sformatf("row%0d stall", i),  {31'd0, stall3},  {31'd0, tbl[i].ea | tbl[i].eb});
      e.we = tbl[i].ewe; e.busy = tbl[i].ebusy; e.waw = tbl[i].ewaw; e.we_z0 = tbl[i].ewe_z0;
      sb.push_back(e);
      @(posedge clk); #1;
      got = sb.pop_front();
      chk($sformatf("row%0d we", i),    {24'd0, we3},   {24'd0, got.we});
      chk($sformatf("row%0d busy", i),  {24'd0, busy3}, {24'd0, got.busy});
      chk($sformatf("row%0d waw", i),   {31'd0, waw3},  {31'd0, got.waw});
      chk($sformatf("row%0d we_z0", i), {24'd0, we_z},  {24'd0, got.we_z0});
    end

    iss_en = 0; wb_en = 0; rd_sel_a = 0; rd_sel_b = 0;

    // Wide variant: top register decode, then reset while it is busy with a wb in flight.
    step5("w5 wb31",    0, 0, 5'd0,  1, 5'd31, 5'd31, 0, 32'h8000_0000, 32'h0000_0000);
    step5("w5 iss31",   0, 1, 5'd31, 0, 5'd0,  5'd31, 0, 32'h0000_0000, 32'h8000_0000);
    step5("w5 hold",    0, 0, 5'd0,  0, 5'd0,  5'd31, 1, 32'h0000_0000, 32'h8000_0000);
    step5("w5 rst",     1, 1, 5'd5,  1, 5'd31, 5'd31, 0, 32'h0000_0000, 32'h0000_0000);
    step5("w5 post",    0, 0, 5'd0,  0, 5'd0,  5'd31, 0, 32'h0000_0000, 32'h0000_0000);

    chk("sb drained", sb.size() + sb5.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
